mc_ctrl_fsm: RTL and testbench

- Moore control FSM that sequences the multi-cycle MIPS datapath: shared instruction/data memory, IR, A/B, ALUOut and MDR registers.
- Supports add, addi, lw, sw, beq and j.
- Drives every datapath mux, write-enable and ALU control.
- Reports illegal instructions and counts retired instructions for the debug display.

---
 rtl/mc_ctrl_pkg.sv | 47 ++++
 rtl/mc_ctrl_decode.sv | 104 ++++++++++
 rtl/mc_ctrl_fsm.sv | 102 ++++++++++
 tb/tb_mc_ctrl_fsm.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// ALU codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXE     = 4'd6,
        S_RWB     = 4'd7,
        S_BR      = 4'd8,
        S_JMP     = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Last state of every legal instruction; these retire it.
    function automatic logic is_terminal(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
               (s == S_BR) || (s == S_JMP) || (s == S_ADDI_WB);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control word decode. Everything is held at 0 while
// rst is high so nothing fires before the synchronous reset has taken effect.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic       rst,
    input  logic [3:0] state,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        if (!rst) begin
            instr_done = is_terminal(state_t'(state));
            case (state)
                S_IF: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALU_ADD;
                    pc_source = PCSRC_ALU;
                end
                // Branch target is precomputed here from PC + offset.
                S_ID: begin
                    alu_src_a = 1'b0;
                    alu_src_b = SRCB_IMM_SH2;
                    alu_op    = ALU_ADD;
                end
                S_MEMADR, S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    reg_dst    = 1'b0;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXE: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_REG;
                    alu_op    = ALU_ADD;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BR: begin
                    alu_src_a     = 1'b1;
                    alu_src_b     = SRCB_REG;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                end
                S_JMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                S_ADDI_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b0;
                    mem_to_reg = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: state register, next-state, illegal flag and
// retired counter. Define MC_SINGLE_STEP_EN for the HALT/step debug mode.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef MC_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic [STATE_W-1:0] state,
    output logic               instr_done,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

`ifdef MC_SINGLE_STEP_EN
    localparam state_t TERM_NEXT = S_HALT;
`else
    localparam state_t TERM_NEXT = S_IF;
`endif

    state_t state_q;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            if (is_terminal(state_q)) retired <= retired + CNT_W'(1);
            case (state_q)
                S_IF: state_q <= S_ID;
                S_ID: begin
                    if (op == OP_LW || op == OP_SW)                state_q <= S_MEMADR;
                    else if (op == OP_RTYPE && funct == FUNCT_ADD) state_q <= S_EXE;
                    else if (op == OP_ADDI)                        state_q <= S_ADDI_EX;
                    else if (op == OP_BEQ)                         state_q <= S_BR;
                    else if (op == OP_J)                           state_q <= S_JMP;
                    else begin
                        state_q <= S_IF;
                        illegal <= 1'b1;
                    end
                end
                S_MEMADR:  state_q <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   state_q <= S_MEMWB;
                S_EXE:     state_q <= S_RWB;
                S_ADDI_EX: state_q <= S_ADDI_WB;
                S_MEMWB, S_MEMWR, S_RWB, S_BR, S_JMP, S_ADDI_WB:
                           state_q <= TERM_NEXT;
`ifdef MC_SINGLE_STEP_EN
                S_HALT:    state_q <= step ? S_IF : S_HALT;
`endif
                // Unused encodings recover to fetch and flag the fault.
                default: begin
                    state_q <= S_IF;
                    illegal <= 1'b1;
                end
            endcase
        end
    end

    mc_ctrl_decode u_decode (
        .rst           (rst),
        .state         (state_q),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done)
    );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm; build with MC_SINGLE_STEP_EN
// to exercise the HALT/step mode instead of the back-to-back sequences.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op = 6'b000000;
    logic [5:0]  funct = 6'b000000;
`ifdef MC_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal;
    logic [1:0]  alu_src_b, pc_source;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic [31:0] retired;

    int tests = 0;
    int fails = 0;
    int exp_retired = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.CNT_W(32), .STATE_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef MC_SINGLE_STEP_EN
        .step          (step),
`endif
        .op            (op),
        .funct         (funct),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .instr_done    (instr_done),
        .illegal       (illegal),
        .retired       (retired)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Park in MEMRD, then reset mid-instruction.
    task automatic test_reset();
        logic [6:0]  strobes;
        logic [10:0] selects;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        op  = 6'b100011;
        tick();
        tick();
        tick();
        tests++;
        if (state !== 4'd3) begin
            fails++;
            $display("[TB] FAIL reset_setup_state: got %0d want 3", state);
        end
        rst = 1'b1;
        #1;
        strobes = {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done};
        selects = {i_or_d, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source};
        tests++;
        if (strobes !== 7'b0) begin
            fails++;
            $display("[TB] FAIL reset_strobes_memrd: got %b want 0000000", strobes);
        end
        tests++;
        if (selects !== 11'b0) begin
            fails++;
            $display("[TB] FAIL reset_selects_memrd: got %b want 0", selects);
        end
        tick();
        tests++;
        if (state !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset_state: got %0d want 0", state);
        end
        strobes = {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done};
        tests++;
        if (strobes !== 7'b0) begin
            fails++;
            $display("[TB] FAIL reset_strobes_if: got %b want 0000000", strobes);
        end
        tick();
        rst = 1'b0;
        #1;
        exp_retired = 0;
        tests++;
        if (retired !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset_retired: got %0d want 0", retired);
        end
        tests++;
        if (illegal !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_illegal: got %b want 0", illegal);
        end
        tests++;
        if (state !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset_release_state: got %0d want 0", state);
        end
    endtask

    task automatic test_lw();
        int seq [6] = '{0, 1, 2, 3, 4, 0};
        int dones = 0;
        op = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (state !== 4'(seq[i])) begin
                fails++;
                $display("[TB] FAIL lw_state[%0d]: got %0d want %0d", i, state, seq[i]);
            end
            tests++;
            if (reg_write !== (seq[i] == 4) || mem_to_reg !== (seq[i] == 4)) begin
                fails++;
                $display("[TB] FAIL lw_wb[%0d]: got reg_write=%b mem_to_reg=%b want %b", i, reg_write, mem_to_reg, seq[i] == 4);
            end
            if (i == 0) begin
                tests++;
                if ({mem_read, ir_write, pc_write, alu_src_b, alu_op, pc_source} !== 10'b111_01_000_00) begin
                    fails++;
                    $display("[TB] FAIL lw_if_word: got %b want 1110100000", {mem_read, ir_write, pc_write, alu_src_b, alu_op, pc_source});
                end
            end
            if (i == 3) begin
                tests++;
                if ({mem_read, i_or_d} !== 2'b11) begin
                    fails++;
                    $display("[TB] FAIL lw_memrd_word: got %b want 11", {mem_read, i_or_d});
                end
            end
            if (instr_done === 1'b1) dones++;
            if (i < 5) tick();
        end
        exp_retired++;
        tests++;
        if (dones != 1) begin
            fails++;
            $display("[TB] FAIL lw_done_pulses: got %0d want 1", dones);
        end
        tests++;
        if (retired !== 32'(exp_retired)) begin
            fails++;
            $display("[TB] FAIL lw_retired: got %0d want %0d", retired, exp_retired);
        end
    endtask

    task automatic test_beq();
        int seq [4] = '{0, 1, 8, 0};
        op = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (state !== 4'(seq[i])) begin
                fails++;
                $display("[TB] FAIL beq_state[%0d]: got %0d want %0d", i, state, seq[i]);
            end
            if (i == 2) begin
                tests++;
                if ({pc_write_cond, pc_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done} !== 11'b1_0_1_00_001_01_1) begin
                    fails++;
                    $display("[TB] FAIL beq_br_word: got %b want 10100001011", {pc_write_cond, pc_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done});
                end
            end
            if (i < 3) tick();
        end
        exp_retired++;
        tests++;
        if (retired !== 32'(exp_retired)) begin
            fails++;
            $display("[TB] FAIL beq_retired: got %0d want %0d", retired, exp_retired);
        end
    endtask

    task automatic test_rtype_add();
        int seq [5] = '{0, 1, 6, 7, 0};
        op    = 6'b000000;
        funct = 6'b100000;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (state !== 4'(seq[i])) begin
                fails++;
                $display("[TB] FAIL add_state[%0d]: got %0d want %0d", i, state, seq[i]);
            end
            if (i == 3) begin
                tests++;
                if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin
                    fails++;
                    $display("[TB] FAIL add_rwb_word: got %b want 110", {reg_write, reg_dst, mem_to_reg});
                end
            end
            if (i < 4) tick();
        end
        exp_retired++;
        tests++;
        if (retired !== 32'(exp_retired)) begin
            fails++;
            $display("[TB] FAIL add_retired: got %0d want %0d", retired, exp_retired);
        end
    endtask

    task automatic test_illegal_funct();
        int seq [3] = '{0, 1, 0};
        int dones = 0;
        op    = 6'b000000;
        funct = 6'b100010;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (state !== 4'(seq[i])) begin
                fails++;
                $display("[TB] FAIL illegal_state[%0d]: got %0d want %0d", i, state, seq[i]);
            end
            if (instr_done === 1'b1) dones++;
            if (i < 2) tick();
        end
        tests++;
        if (illegal !== 1'b1 || dones != 0) begin
            fails++;
            $display("[TB] FAIL illegal_flag: got illegal=%b dones=%0d want 1/0", illegal, dones);
        end
        tests++;
        if (retired !== 32'(exp_retired)) begin
            fails++;
            $display("[TB] FAIL illegal_retired: got %0d want %0d", retired, exp_retired);
        end
    endtask

    // j, sw, addi issued back to back; op switches at each fetch.
    task automatic test_back_to_back();
        int         seq [12] = '{0, 1, 9, 0, 1, 2, 5, 0, 1, 10, 11, 0};
        logic [5:0] ops [12];
        ops = '{6'b000010, 6'b000010, 6'b000010,
                6'b101011, 6'b101011, 6'b101011, 6'b101011,
                6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b001000};
        funct = 6'b000000;
        for (int i = 0; i < 12; i++) begin
            op = ops[i];
            #1;
            tests++;
            if (state !== 4'(seq[i])) begin
                fails++;
                $display("[TB] FAIL b2b_state[%0d]: got %0d want %0d", i, state, seq[i]);
            end
            tests++;
            if (mem_write !== (seq[i] == 5)) begin
                fails++;
                $display("[TB] FAIL b2b_mem_write[%0d]: got %b want %b", i, mem_write, seq[i] == 5);
            end
            if (seq[i] == 9) begin
                tests++;
                if ({pc_write, pc_source} !== 3'b1_10) begin
                    fails++;
                    $display("[TB] FAIL b2b_jmp_word: got %b want 110", {pc_write, pc_source});
                end
            end
            if (i < 11) tick();
        end
        exp_retired += 3;
        tests++;
        if (retired !== 32'(exp_retired)) begin
            fails++;
            $display("[TB] FAIL b2b_retired: got %0d want %0d", retired, exp_retired);
        end
    endtask

`ifdef MC_SINGLE_STEP_EN
    task automatic test_single_step();
        op   = 6'b000010;
        step = 1'b0;
        tick();
        tick();
        tick();
        exp_retired++;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (state !== 4'd12) begin
                fails++;
                $display("[TB] FAIL step_halt_state[%0d]: got %0d want 12", i, state);
            end
            tests++;
            if ({pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done} !== 7'b0) begin
                fails++;
                $display("[TB] FAIL step_halt_strobes[%0d]: got %b want 0", i,
                         {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done});
            end
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        tests++;
        if (state !== 4'd0) begin
            fails++;
            $display("[TB] FAIL step_resume_state: got %0d want 0", state);
        end
        tests++;
        if (retired !== 32'(exp_retired)) begin
            fails++;
            $display("[TB] FAIL step_retired: got %0d want %0d", retired, exp_retired);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef MC_SINGLE_STEP_EN
        test_illegal_funct();
        test_single_step();
`else
        test_lw();
        test_beq();
        test_rtype_add();
        test_illegal_funct();
        test_back_to_back();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
